// File: rtl/pc_fetch.sv
// Program counter / fetch address stage feeding a combinational instruction ROM.
// Optional return stack enabled by defining PC_STACK_EN.
module pc_fetch #(
    parameter int AWIDTH      = 8,
    parameter int RESET_VEC   = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              jmp_i,
    input  logic              br_req_i,
    input  logic              br_cond_i,
    input  logic              call_i,
    input  logic              ret_i,
    input  logic              halt_i,
    input  logic [AWIDTH-1:0] target_i,
    output logic [AWIDTH-1:0] addr_o,
    output logic              halted_o,
    output logic              stk_err_o
);

    localparam logic [AWIDTH-1:0] RST_ADDR = AWIDTH'(RESET_VEC);

    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              halted_q, halted_d;
    logic [AWIDTH-1:0] incr;

    // Natural width truncation gives the modulo-2^AWIDTH wrap.
    assign incr = addr_q + 1'b1;

`ifdef PC_STACK_EN
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [AWIDTH-1:0] stk_q [0:(1<<IW)-1];
    logic [SPW-1:0]    sp_q;
    logic              err_q, err_d;
    logic              push, pop;
    logic              stk_empty, stk_full;
    logic [IW-1:0]     wr_idx, rd_idx;

    assign stk_empty = (sp_q == '0);
    assign stk_full  = (sp_q == SPW'(STACK_DEPTH));
    assign wr_idx    = IW'(sp_q);
    assign rd_idx    = IW'(sp_q - 1'b1);
    assign stk_err_o = err_q;
`else
    assign stk_err_o = 1'b0;
`endif

    always_comb begin
        addr_d   = addr_q;
        halted_d = halted_q;
`ifdef PC_STACK_EN
        err_d    = err_q;
        push     = 1'b0;
        pop      = 1'b0;
`endif
        if (en_i && !halted_q) begin
            if (halt_i) begin
                halted_d = 1'b1;
            end else if (ret_i) begin
`ifdef PC_STACK_EN
                if (stk_empty) begin
                    addr_d = incr;
                    err_d  = 1'b1;
                end else begin
                    addr_d = stk_q[rd_idx];
                    pop    = 1'b1;
                end
`else
                addr_d = incr;
`endif
            end else if (call_i) begin
                addr_d = target_i;
`ifdef PC_STACK_EN
                // A call on a full stack still jumps; only the return address is lost.
                if (stk_full) err_d = 1'b1;
                else          push  = 1'b1;
`endif
            end else if (jmp_i || (br_req_i && br_cond_i)) begin
                addr_d = target_i;
            end else begin
                addr_d = incr;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q   <= RST_ADDR;
            halted_q <= 1'b0;
`ifdef PC_STACK_EN
            err_q    <= 1'b0;
            sp_q     <= '0;
`endif
        end else begin
            addr_q   <= addr_d;
            halted_q <= halted_d;
`ifdef PC_STACK_EN
            err_q    <= err_d;
            if (push)     sp_q <= sp_q + 1'b1;
            else if (pop) sp_q <= sp_q - 1'b1;
`endif
        end
    end

`ifdef PC_STACK_EN
    // Entries above the stack pointer are dead, so storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) stk_q[wr_idx] <= incr;
    end
`endif

    assign addr_o   = addr_q;
    assign halted_o = halted_q;

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Program-counter / fetch-address stage directly upstream of the instruction ROM.
- Holds the current instruction address and drives it onto the ROM ADDR input.
- Each cycle it computes the next address from decoded control (sequential, jump, conditional branch, call/return, halt).
- The ROM is combinational, so the registered ADDR output gives a one-cycle-per-instruction fetch.

Parameters:
- AWIDTH, 8, address width; must match the ROM AWIDTH.
- RESET_VEC, 0, address loaded on reset.
- STACK_DEPTH, 4, return-stack entries; used only with PC_STACK_EN, must be ≥1.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  advance enable; 0 = stall, all state holds.
- JMP  in  1  unconditional jump to TARGET.
- BR_REQ  in  1  conditional branch request.
- BR_COND  in  1  branch condition from ALU flags; the branch is taken when BR_REQ=1 and BR_COND=1.
- CALL  in  1  subroutine call to TARGET.
- RET  in  1  return from subroutine.
- HALT  in  1  stop fetching.
- TARGET  in  AWIDTH  jump/branch/call destination (instruction operand field).
- ADDR  out  AWIDTH  current instruction address, to ROM ADDR.
- HALTED  out  1  sticky halt indicator.
- STK_ERR  out  1  sticky return-stack overflow/underflow flag.

Behaviour:
- Reset (RST=1 at a rising edge, regardless of EN or any other input):
  - ADDR = RESET_VEC; HALTED = 0; STK_ERR = 0; stack pointer = 0 (empty).
- Latency: a request sampled at edge N takes effect at edge N; the new ADDR is visible after that edge. No other pipeline delay.
- Hold conditions: when EN=0 or HALTED=1, ADDR, stack and flags all hold. RST still acts.
- Next-address priority when EN=1 and HALTED=0 (highest first):
  1. HALT: HALTED←1, ADDR holds.
  2. RET: ADDR←popped value.
  3. CALL: push ADDR+1, ADDR←TARGET.
  4. JMP: ADDR←TARGET.
  5. Branch taken: ADDR←TARGET.
  6. Otherwise: ADDR←ADDR+1.
- Increment is modulo 2^AWIDTH: ADDR all-ones +1 wraps to 0, no flag. The CALL push value wraps the same way.
- Simultaneous requests are resolved strictly by the priority list; lower-priority requests are ignored that cycle.
- Branch not taken (BR_REQ=1, BR_COND=0) behaves exactly as sequential increment.
- HALTED is sticky. Only RST clears it.
- Reset mid-operation (during a stall, halt, or with a non-empty stack) fully restores reset values in that cycle; stack contents are discarded.

Optional Feature:
- Macro: PC_STACK_EN.
- Defined: LIFO return stack of STACK_DEPTH entries × AWIDTH bits.
  - CALL on a full stack: the jump is still performed, the push is dropped, STK_ERR←1.
  - RET on an empty stack: ADDR←ADDR+1, STK_ERR←1.
  - Push and pop never occur in the same cycle (RET has priority over CALL).
- Not defined: no stack storage.
  - CALL behaves exactly as JMP.
  - RET behaves as sequential increment.
  - STK_ERR is tied to 0.

Test Plan:
- Reset then 3 cycles EN=1, no requests -> ADDR 00,01,02,03. Then EN=0 for 2 cycles -> ADDR stays 03.
- ADDR=09, JMP=1, TARGET=03 -> ADDR=03. ADDR=05, BR_REQ=1, BR_COND=0 -> 06; BR_COND=1, TARGET=0E -> 0E.
- ADDR=FF, no request -> ADDR=00 and STK_ERR stays 0. JMP=1 with HALT=1 at ADDR=04 -> ADDR stays 04, HALTED=1; subsequent JMP ignored; RST -> ADDR=00, HALTED=0.
- PC_STACK_EN: ADDR=02, CALL, TARGET=20 -> ADDR=20. Then 2 increments -> ADDR=22. Then RET -> ADDR=03, stack empty.
- PC_STACK_EN, STACK_DEPTH=4: five nested CALLs -> fifth jumps but STK_ERR=1. Four RETs unwind correctly. A fifth RET at ADDR=X -> ADDR=X+1, STK_ERR stays 1.
- Without PC_STACK_EN: CALL, TARGET=30 at ADDR=07 -> ADDR=30. Then RET -> ADDR=31; STK_ERR=0 throughout.
